// File: rtl/scroll_controller.sv
`default_nettype none
// ============================================================================
//  Module      : scroll_controller
//  Description : Scrolling-message sequencer. Walks a six-digit window over a
//                fixed eight-symbol message ("CPEN 311"), one position per
//                scroll period, and issues the load strobes for the display
//                datapath (hex_en to load the window, ledr_en per step).
//  Revision    : 1.0 - initial release
// ============================================================================
module scroll_controller #(
   parameter int CLK_DIV = 50000000,
   parameter int MSG_LEN = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       dir,
   input  logic       pause,
   output logic       ledr_en,
   output logic       hex_en,
   output logic [6:0] next_hex0,
   output logic [6:0] next_hex1,
   output logic [6:0] next_hex2,
   output logic [6:0] next_hex3,
   output logic [6:0] next_hex4,
   output logic [6:0] next_hex5,
   output logic [2:0] scroll_pos
);

   // Active-low 7-segment codes, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] c_hex_c   = 7'b1000110;
   localparam logic [6:0] c_hex_p   = 7'b0001100;
   localparam logic [6:0] c_hex_e   = 7'b0000110;
   localparam logic [6:0] c_hex_n   = 7'b1001000;
   localparam logic [6:0] c_hex_off = 7'b1111111;
   localparam logic [6:0] c_hex_3   = 7'b0110000;
   localparam logic [6:0] c_hex_1   = 7'b1111001;

   // Position width follows the message length; a power-of-two length lets
   // the position counter wrap on its own.
   localparam int c_pos_w = $clog2(MSG_LEN);
   localparam int c_cnt_w = $clog2(CLK_DIV);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      S_INIT = 2'd0,
      S_SHOW = 2'd1,
      S_WAIT = 2'd2,
      S_STEP = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [c_pos_w-1:0]   r_pos;
   logic                 w_cnt_done;
   logic [6:0]           w_win [0:5];

   // Message ROM: "CPEN 311"
   function automatic logic [6:0] msg_rom(input logic [c_pos_w-1:0] idx);
      logic [6:0] code;
      case (idx)
         3'd0:    code = c_hex_c;
         3'd1:    code = c_hex_p;
         3'd2:    code = c_hex_e;
         3'd3:    code = c_hex_n;
         3'd4:    code = c_hex_off;
         3'd5:    code = c_hex_3;
         3'd6:    code = c_hex_1;
         default: code = c_hex_1;
      endcase
      return code;
   endfunction

   assign w_cnt_done = (r_cnt == c_cnt_last);

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_INIT;
      else       r_state <= w_state_nxt;
   end

   // Next-state decode and Moore strobes
   always_comb begin
      w_state_nxt = r_state;
      hex_en      = 1'b0;
      ledr_en     = 1'b0;
      case (r_state)
         S_INIT: w_state_nxt = S_SHOW;
         S_SHOW: begin
            hex_en      = 1'b1;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // pause only matters once the wait count has expired
            if (w_cnt_done && !pause) w_state_nxt = S_STEP;
         end
         S_STEP: begin
            ledr_en     = 1'b1;
            w_state_nxt = S_SHOW;
         end
         default: w_state_nxt = S_INIT;
      endcase
   end

   // Wait-phase counter: cleared on SHOW, counts up in WAIT, parks at the
   // terminal value while paused
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else begin
         case (r_state)
            S_WAIT: begin
               if (!w_cnt_done)  r_cnt <= r_cnt + 1'b1;
               else if (!pause)  r_cnt <= '0;
            end
            default: r_cnt <= '0;
         endcase
      end
   end

   // Window position: moves one place on the STEP exit edge, dir sampled here
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pos <= '0;
      end else if (r_state == S_STEP) begin
         if (dir) r_pos <= r_pos + 1'b1;
         else     r_pos <= r_pos - 1'b1;
      end
   end

   // Window decode: digit k shows message symbol p+5-k, so hex5 is leftmost
   for (genvar gi = 0; gi < 6; gi++) begin : g_window
      assign w_win[gi] = msg_rom(r_pos + c_pos_w'(5 - gi));
   end

   assign next_hex0  = w_win[0];
   assign next_hex1  = w_win[1];
   assign next_hex2  = w_win[2];
   assign next_hex3  = w_win[3];
   assign next_hex4  = w_win[4];
   assign next_hex5  = w_win[5];
   assign scroll_pos = r_pos;

endmodule
`default_nettype wire

// File: tb/tb_scroll_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scroll_controller
//  Description : Scoreboard bench for scroll_controller with CLK_DIV=4
//                (six-cycle scroll period).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scroll_controller;

   localparam int CLK_DIV = 4;

   localparam logic [6:0] C   = 7'b1000110;
   localparam logic [6:0] P   = 7'b0001100;
   localparam logic [6:0] E   = 7'b0000110;
   localparam logic [6:0] N   = 7'b1001000;
   localparam logic [6:0] OFF = 7'b1111111;
   localparam logic [6:0] D3  = 7'b0110000;
   localparam logic [6:0] D1  = 7'b1111001;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       dir = 1'b0;
   logic       pause = 1'b0;
   logic       ledr_en, hex_en;
   logic [6:0] next_hex0, next_hex1, next_hex2, next_hex3, next_hex4, next_hex5;
   logic [2:0] scroll_pos;
   logic [41:0] win;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit is_hex;
      int pos;
      int gap;   // cycles since previous strobe, -1 = not checked
   } ev_t;

   ev_t q[$];
   ev_t e;
   int  since = 0;

   always #5 clk = ~clk;

   scroll_controller #(.CLK_DIV(CLK_DIV), .MSG_LEN(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .dir        (dir),
      .pause      (pause),
      .ledr_en    (ledr_en),
      .hex_en     (hex_en),
      .next_hex0  (next_hex0),
      .next_hex1  (next_hex1),
      .next_hex2  (next_hex2),
      .next_hex3  (next_hex3),
      .next_hex4  (next_hex4),
      .next_hex5  (next_hex5),
      .scroll_pos (scroll_pos)
   );

   assign win = {next_hex5, next_hex4, next_hex3, next_hex2, next_hex1, next_hex0};

   function automatic logic [6:0] tb_msg(input int i);
      case (i)
         0: return C;
         1: return P;
         2: return E;
         3: return N;
         4: return OFF;
         5: return D3;
         default: return D1;
      endcase
   endfunction

   // hex5 = msg[p], hex4 = msg[p+1] ... hex0 = msg[p+5]
   function automatic logic [41:0] exp_win(input int p);
      logic [41:0] r;
      for (int j = 0; j < 6; j++) r[j*7 +: 7] = tb_msg((p + 5 - j) % 8);
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input bit is_hex, input int pos, input int gap);
      ev_t t;
      t.is_hex = is_hex;
      t.pos    = pos;
      t.gap    = gap;
      q.push_back(t);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every strobe pops the next expected event
   always @(negedge clk) begin
      since++;
      chk("strobe_excl", 64'(hex_en & ledr_en), 64'd0);
      if (hex_en || ledr_en) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_strobe: got hex_en=%0b ledr_en=%0b expected none at %0t",
                     hex_en, ledr_en, $time);
         end else begin
            e = q.pop_front();
            chk("ev_kind_hex", 64'(hex_en), 64'(e.is_hex));
            chk("ev_pos", 64'(scroll_pos), 64'(e.pos));
            chk("ev_window", 64'(win), 64'(exp_win(e.pos)));
            if (e.gap >= 0) chk("ev_gap", 64'(since), 64'(e.gap));
         end
         since = 0;
      end
   end

   initial begin
      // Scenario 1: reset for two edges
      push(1'b1, 0, -1);
      for (int n = 1; n <= 8; n++) begin
         push(1'b0, (9 - n) % 8, 5);
         push(1'b1, 8 - n, 1);
      end
      tick();
      tick();
      chk("reset_pos", 64'(scroll_pos), 64'd0);
      chk("reset_hex_en", 64'(hex_en), 64'd0);
      chk("reset_ledr_en", 64'(ledr_en), 64'd0);
      reset = 1'b0;
      tick();   // INIT -> SHOW
      chk("s1_hex_en", 64'(hex_en), 64'd1);
      chk("s1_pos", 64'(scroll_pos), 64'd0);
      chk("s1_window", 64'(win), 64'({C, P, E, N, OFF, D3}));

      // Scenario 2/5: eight right steps
      repeat (6) tick();
      chk("s2_hex_en", 64'(hex_en), 64'd1);
      chk("s2_pos", 64'(scroll_pos), 64'd7);
      chk("s2_window", 64'(win), 64'({D1, C, P, E, N, OFF}));
      repeat (6) tick();
      chk("s2b_window", 64'(win), 64'({D1, D1, C, P, E, N}));
      repeat (36) tick();
      chk("s5_hex_en", 64'(hex_en), 64'd1);
      chk("s5_pos", 64'(scroll_pos), 64'd0);
      chk("s5_window", 64'(win), 64'({C, P, E, N, OFF, D3}));

      // Scenario 3: one left step from pos 0
      dir = 1'b1;
      push(1'b0, 0, 5);
      push(1'b1, 1, 1);
      repeat (6) tick();
      chk("s3_hex_en", 64'(hex_en), 64'd1);
      chk("s3_pos", 64'(scroll_pos), 64'd1);
      chk("s3_window", 64'(win), 64'({P, E, N, OFF, D3, D1}));

      // Scenario 4: pause raised early, held 10 cycles past terminal count
      pause = 1'b1;
      push(1'b0, 1, 15);
      push(1'b1, 2, 1);
      for (int i = 0; i < 14; i++) begin
         tick();
         chk("s4_hold_pos", 64'(scroll_pos), 64'd1);
         chk("s4_hold_strobes", 64'({hex_en, ledr_en}), 64'd0);
      end
      pause = 1'b0;
      push(1'b0, 2, 5);
      push(1'b1, 3, 1);
      push(1'b0, 3, 5);
      push(1'b1, 4, 1);
      push(1'b0, 4, 5);
      push(1'b1, 5, 1);
      tick();
      chk("s4_release_ledr", 64'(ledr_en), 64'd1);
      tick();
      chk("s4_release_hex", 64'(hex_en), 64'd1);
      chk("s4_release_pos", 64'(scroll_pos), 64'd2);

      // Scenario 6: reset mid-WAIT at pos 5, cnt=2
      repeat (21) tick();
      chk("s6_pre_pos", 64'(scroll_pos), 64'd5);
      reset = 1'b1;
      push(1'b1, 0, -1);
      tick();
      chk("s6_rst_strobes", 64'({hex_en, ledr_en}), 64'd0);
      chk("s6_rst_pos", 64'(scroll_pos), 64'd0);
      reset = 1'b0;
      tick();
      chk("s6_hex_en", 64'(hex_en), 64'd1);
      chk("s6_window", 64'(win), 64'({C, P, E, N, OFF, D3}));
      repeat (3) tick();
      @(negedge clk);
      #1;
      chk("queue_empty", 64'(q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/scroll_controller.md
Name: scroll_controller

Overview:
- FSM sequencer for the scrolling display datapath.
- Generates the `ledr_en` and `hex_en` load strobes and presents the six-character window (`next_hex0`..`next_hex5`) of a fixed 8-symbol message.
- Steps the window by one position every scroll period, left or right, with pause support.
- Sits between the board inputs (SW/KEY) and the datapath; all outputs connect directly to the same-named datapath inputs.

Parameters:
- CLK_DIV, default 50000000: WAIT-phase length in clk cycles. Legal range ≥2. Full scroll period = CLK_DIV+2 cycles.
- MSG_LEN, default 8: message length. Fixed at 8 in this revision; `scroll_pos` is 3 bits and wraps naturally.

Ports:
- clk  input  1  system clock; the block's only clock.
- reset  input  1  synchronous, active-high reset.
- dir  input  1  scroll direction: 0 = right (pos-1), 1 = left (pos+1).
- pause  input  1  1 = hold the current window at the terminal count.
- ledr_en  output  1  one-cycle strobe per scroll step; advances the datapath LEDR register.
- hex_en  output  1  one-cycle strobe; datapath loads `next_hex*` on this cycle's rising edge.
- next_hex0..next_hex5  output  7 each  active-low 7-seg codes. `next_hex5` is the leftmost digit.
- scroll_pos  output  3  current window start index into the message.

Behaviour:
- Message ROM, index 0..7, using the `defines.sv` codes: HEX_C, HEX_P, HEX_E, HEX_N, HEX_OFF, HEX_3, HEX_1, HEX_1 ("CPEN 311").
- Window mapping, combinational from the registered `scroll_pos` (p), all indices mod 8: next_hex5=msg[p], next_hex4=msg[p+1], next_hex3=msg[p+2], next_hex2=msg[p+3], next_hex1=msg[p+4], next_hex0=msg[p+5].
- States: S_INIT, S_SHOW, S_WAIT, S_STEP. Outputs are Moore: hex_en=(state==S_SHOW), ledr_en=(state==S_STEP).
- Reset (synchronous, checked at each rising edge): state=S_INIT, scroll_pos=0, cnt=0. ledr_en=0 and hex_en=0 throughout reset and in S_INIT.
- S_INIT -> S_SHOW, unconditional.
- S_SHOW: hex_en=1 for exactly one cycle. cnt<=0. Next state S_WAIT.
- S_WAIT: cnt increments each cycle; cnt width = $clog2(CLK_DIV).
  - When cnt==CLK_DIV-1 and pause=0: go to S_STEP, cnt<=0.
  - When cnt==CLK_DIV-1 and pause=1: stay in S_WAIT, cnt holds at CLK_DIV-1.
  - pause is ignored before the terminal count.
- S_STEP: ledr_en=1 for one cycle. On the exit edge, scroll_pos<=scroll_pos-1 (dir=0) or +1 (dir=1), mod 8. dir is sampled in S_STEP only. Next state S_SHOW.
- Ordering: the new window is valid in S_SHOW, the cycle after the LEDR strobe. The first S_SHOW after reset shows pos 0 with no preceding ledr_en.
- Timing:
  - Steady-state period is CLK_DIV+2 cycles from one hex_en to the next.
  - hex_en and ledr_en are never high in the same cycle.
  - After pause falls at the terminal count, S_STEP is entered on the next edge.
- Wrap: pos 0 with dir=0 -> pos 7; pos 7 with dir=1 -> pos 0. There is no terminal condition; scrolling is continuous.
- Reset mid-operation, in any state: the next edge forces S_INIT and pos 0. Any in-progress step is discarded with no partial strobes.
- Changing dir mid-WAIT has effect only at the next S_STEP.
- Simultaneous reset and pause: reset wins.

Test Plan:
All scenarios use CLK_DIV=4, so the period is 6 cycles.
1. Reset high for 2 cycles, then low. Required:
   - cycle 1 (S_INIT): hex_en=0, ledr_en=0.
   - cycle 2: hex_en=1, window hex5..hex0 = C,P,E,N,OFF,3, scroll_pos=0.
2. dir=0, pause=0 from scenario 1. Required:
   - hex_en low for 4 WAIT cycles, then ledr_en=1 for 1 cycle.
   - Next cycle: hex_en=1, window = 1,C,P,E,N,OFF, scroll_pos=7.
   - Next hex_en exactly 6 cycles later: window = 1,1,C,P,E,N, pos 6.
3. dir=1 from pos 0. Required: after ledr_en, hex_en with window P,E,N,OFF,3,1, scroll_pos=1.
4. pause=1 held across the terminal count for 10 cycles. Required:
   - No ledr_en or hex_en during the hold; scroll_pos unchanged.
   - Release pause: ledr_en=1 on the next cycle, hex_en the cycle after.
5. dir=0 for 8 steps from pos 0. Required: exactly 8 ledr_en and 8 hex_en pulses; positions 7,6,...,0; final window = C,P,E,N,OFF,3.
6. Reset asserted for 1 cycle mid-WAIT at pos 5 (cnt=2). Required:
   - Next cycle: ledr_en=hex_en=0, scroll_pos=0.
   - Then S_SHOW with the C,P,E,N,OFF,3 window.
